cla_add_sequencer: RTL and testbench

//  Initiator for the 4-bit cla_adder en/ready interface. Accepts a WIDTH-bit add request,

---
 rtl/cla_add_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cla_add_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_sequencer.sv
// Drives a 4-bit adder over an en/ready handshake to add two WIDTH-bit operands,
// one nibble at a time LSB-first, chaining the carry between nibble operations.
module cla_add_sequencer #(
  parameter int NIBBLES = 2,
  parameter int TIMEOUT = 15,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             zero,
  output logic             error,
  output logic             add_en,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c_in,
  input  logic             add_ready,
  input  logic [3:0]       add_out,
  input  logic             add_c_out,
  output logic [1:0]       dbg_state
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // Handshake: add_en is a one-cycle pulse in ISSUE; add_a/add_b/add_c_in stay stable
  // from that pulse until add_ready is seen in WAIT. add_ready outside WAIT is ignored.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [IW-1:0]    r_idx;
  logic [TW-1:0]    r_timer;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_zero;
  logic             r_err;

  logic             w_accept;
  logic             w_take;
  logic             w_last;
  logic             w_finish;
  logic             w_tick;
  logic             w_to;
  logic [WIDTH-1:0] w_acc_next;

  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_take     = 1'b0;
    w_finish   = 1'b0;
    w_tick     = 1'b0;
    w_to       = 1'b0;
    w_acc_next = r_acc;
    w_acc_next[4*r_idx +: 4] = add_out;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (add_ready) begin
          w_take   = 1'b1;
          w_finish = w_last;
          w_next   = w_last ? S_DONE : S_ISSUE;
        end else if (r_timer == TMO_LAST) begin
          w_to   = 1'b1;
          w_next = S_DONE;
        end else begin
          w_tick = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= op_b;
        r_carry <= carry_in;
        r_idx   <= '0;
        r_acc   <= '0;
        r_err   <= 1'b0;
      end
      if (r_state == S_ISSUE) r_timer <= '0;
      if (w_tick) r_timer <= r_timer + 1'b1;
      if (w_take) begin
        r_acc   <= w_acc_next;
        r_carry <= add_c_out;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
      // Visible results change only on entry to DONE, so they line up with the done pulse.
      if (w_finish) begin
        r_sum  <= w_acc_next;
        r_cout <= add_c_out;
        r_zero <= (w_acc_next == '0);
      end
      if (w_to) begin
        r_sum  <= '0;
        r_cout <= 1'b0;
        r_zero <= 1'b0;
        r_err  <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign add_en    = (r_state == S_ISSUE);
  assign add_a     = r_a[4*r_idx +: 4];
  assign add_b     = r_b[4*r_idx +: 4];
  assign add_c_in  = r_carry;
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign zero      = r_zero;
  assign error     = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Bench for cla_add_sequencer: an adder responder with programmable latency, a driver task
// per add request, and a scoreboard fed from plain-arithmetic expected results.
module tb_cla_add_sequencer;

  localparam int NIBBLES = 2;
  localparam int TIMEOUT = 15;
  localparam int WIDTH   = 4 * NIBBLES;
  localparam int EW      = WIDTH + 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             zero;
  logic             error;
  logic             add_en;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_c_in;
  logic             add_ready;
  logic [3:0]       add_out;
  logic             add_c_out;
  logic [1:0]       dbg_state;

  cla_add_sequencer #(.NIBBLES(NIBBLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
    .carry_out(carry_out), .zero(zero), .error(error), .add_en(add_en),
    .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in), .add_ready(add_ready),
    .add_out(add_out), .add_c_out(add_c_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // expected word = {error, zero, carry_out, sum}
  logic [EW-1:0] exp_q[$];
  logic [WIDTH-1:0] prev_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- adder responder ----------------
  int         resp_lat = 1;
  bit         resp_pend = 0;
  int         resp_cnt = 0;
  int         en_cnt = 0;
  bit         stray_req = 0;
  logic [3:0] cap_a;
  logic [3:0] cap_b;
  logic       cap_c;
  logic [4:0] nib_sum;

  always @(negedge clk) begin
    add_ready = 1'b0;
    add_out   = 4'h0;
    add_c_out = 1'b0;
    if (!rst_n) begin
      resp_pend = 0;
    end else begin
      if (resp_pend) begin
        check("operand_stable", 32'({add_a, add_b, add_c_in}), 32'({cap_a, cap_b, cap_c}));
        resp_cnt--;
        if (resp_cnt == 0) begin
          nib_sum   = 5'(cap_a) + 5'(cap_b) + 5'(cap_c);
          add_out   = nib_sum[3:0];
          add_c_out = nib_sum[4];
          add_ready = 1'b1;
          resp_pend = 0;
        end
      end
      if (add_en) begin
        en_cnt++;
        cap_a = add_a;
        cap_b = add_b;
        cap_c = add_c_in;
        if (resp_lat > 0) begin
          resp_pend = 1;
          resp_cnt  = resp_lat;
        end
      end else if (stray_req && !resp_pend && !add_ready) begin
        add_ready = 1'b1;
        add_out   = 4'($urandom_range(0, 15));
        add_c_out = 1'($urandom_range(0, 1));
        stray_req = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // lat = 0 means the responder never answers.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int lat, input bit intrude);
    logic [WIDTH:0] full;
    logic [EW-1:0]  exp_w;
    logic [EW-1:0]  got_w;
    int             n;
    bit             got;
    full = WIDTH'(a) + WIDTH'(b) + WIDTH'(cin);
    if (lat == 0) exp_w = {1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}};
    else          exp_w = {1'b0, (full[WIDTH-1:0] == '0), full[WIDTH], full[WIDTH-1:0]};
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));
    resp_lat = lat;
    en_cnt   = 0;
    start    = 1'b1;
    op_a     = a;
    op_b     = b;
    carry_in = cin;
    exp_q.push_back(exp_w);
    got = 0;
    n   = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        op_a  = WIDTH'($urandom);
        op_b  = WIDTH'($urandom);
        check("busy_after_start", 32'(busy), 32'(1));
      end
      if (n == 2) begin
        check("result_held", 32'(sum), 32'(prev_sum));
        if (intrude) begin
          start    = 1'b1;
          op_a     = WIDTH'($urandom);
          op_b     = WIDTH'($urandom);
          carry_in = ~cin;
        end
      end
      if (n == 3) start = 1'b0;
      if (done) got = 1;
    end
    if (!got) begin
      check("done_seen", 32'(0), 32'(1));
      void'(exp_q.pop_front());
    end else begin
      exp_w = exp_q.pop_front();
      got_w = {error, zero, carry_out, sum};
      check("result", 32'(got_w), 32'(exp_w));
      if (lat > 0) begin
        check("latency", 32'(n), 32'(NIBBLES * (lat + 1) + 1));
        check("add_en_count", 32'(en_cnt), 32'(NIBBLES));
      end else begin
        check("timeout_latency", 32'((n - 1 == TIMEOUT) || (n - 1 == TIMEOUT + 1)), 32'(1));
        check("add_en_count", 32'(en_cnt), 32'(1));
      end
      prev_sum = exp_w[WIDTH-1:0];
      // a start in the DONE cycle must be ignored
      start = 1'b1;
      op_a  = WIDTH'($urandom);
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", 32'(done), 32'(0));
      check("start_in_done_ignored", 32'(busy), 32'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    op_a      = '0;
    op_b      = '0;
    carry_in  = 1'b0;
    add_ready = 1'b0;
    add_out   = '0;
    add_c_out = 1'b0;
    prev_sum  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, error, zero, carry_out, add_en, sum}), 32'(0));
    rst_n = 1'b1;

    run_op(8'h01, 8'h02, 1'b0, 1, 1'b0);
    run_op(8'h0F, 8'h01, 1'b0, 1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0);
    run_op(8'h12, 8'h34, 1'b1, 3, 1'b0);
    run_op(8'hA5, 8'h11, 1'b0, 0, 1'b0);
    run_op(8'h20, 8'h22, 1'b1, 1, 1'b0);
    run_op(8'h33, 8'h44, 1'b0, 2, 1'b1);

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    resp_lat = 3;
    start    = 1'b1;
    op_a     = 8'h77;
    op_b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 32'({add_en, busy, done}), 32'(0));
    check("async_reset_data", 32'({sum, carry_out, zero, error}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_sum = '0;
    stray_req = 1;
    @(negedge clk);
    @(negedge clk);
    check("stray_ready_ignored", 32'({busy, sum}), 32'(0));
    run_op(8'h05, 8'h03, 1'b0, 1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) stray_req = 1;
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
